nn_frame_sequencer: RTL and testbench
=====================================

// Module: nn_frame_sequencer
// PURPOSE
// - Front-end controller for the MNIST inference datapath. Receives one 784-bit binary image over the
//   Arduino two-wire serial link (ser_clk/ser_data), holds it stable as the network input, then steps
//   each layer through a start/done handshake, and latches the argmax class for HEX display.
// - Sits between the ARDUINO_IO pins and the layer engines inside top.
// PARAMETERS
// - N_PIXELS    784   bits per frame; first bit received lands in pixels[N_PIXELS-1]
// - N_LAYERS    3     layers sequenced in order 0..N_LAYERS-1
// - CLASS_W     4     width of argmax class index
// - GAP_CYCLES  4096  max CLOCK_50 cycles between ser_clk rising edges inside a frame
// PORTS
// - CLOCK_50      in   1         system clock, all state on rising edge
// - resetn        in   1         asynchronous active-low reset
// - ser_clk       in   1         serial bit clock, asynchronous, data valid at its rising edge
// - ser_data      in   1         serial data, asynchronous
// - pixels        out  N_PIXELS  frame buffer driven to layer 0
// - layer_start   out  N_LAYERS  one-hot, one-cycle start pulse to layer k
// - layer_done    in   N_LAYERS  layer k finished (pulse or level)
// - class_in      in   CLASS_W   argmax output of final layer
// - result        out  CLASS_W   latched class
// - result_valid  out  1         result holds a class from the last completed frame
// - busy          out  1         high in RECV, START, WAIT
// - frame_err     out  1         sticky: last frame aborted (gap timeout or overrun)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, bit/layer counters 0, sync flops 0.
// - Input sync: ser_clk and ser_data each through 2 flops; 3rd flop on ser_clk gives rising-edge
//   strobe. Synced data sampled on the strobe cycle. ser_clk high and low each >= 2 CLOCK_50 periods.
// - Shift: pixels <= {pixels[N_PIXELS-2:0], bit} on each accepted strobe. pixels is unchanged in every
//   other state.
// - IDLE: on strobe, shift bit, bit_cnt=1, clear result_valid and frame_err, go RECV.
// - RECV: each strobe shifts, bit_cnt++, gap counter clears. When the N_PIXELS-th bit is shifted in,
//   go START next cycle. Gap counter reaching GAP_CYCLES: frame_err=1, go IDLE, pixels keep the
//   partial contents, result_valid stays 0.
// - START: layer_start[layer_idx]=1 for exactly this cycle, go WAIT.
//   layer_start[0] fires the cycle after the last bit is shifted in.
// - WAIT: only layer_done[layer_idx] is sampled; other done bits are ignored. Done is ignored in the
//   START cycle itself. On done: if layer_idx==N_LAYERS-1 go DONE, else layer_idx++ and go START.
// - DONE (one cycle): result<=class_in, result_valid<=1, layer_idx<=0, go IDLE.
//   result is visible the 2nd cycle after the final done.
// - Overrun: a strobe in START/WAIT/DONE sets frame_err=1. The bit is discarded and sequencing
//   continues.
// - No timeout in WAIT; reset is the only escape from a hung layer.
// - Reset mid-operation: immediate return to reset values. A partial frame is discarded.
// - busy = (state==RECV || state==START || state==WAIT).
// STRUCTURE
// - Package nn_ctrl_pkg: state enum {IDLE,RECV,START,WAIT,DONE}; localparams N_PIXELS_DEF=784,
//   CNT_W=$clog2(N_PIXELS+1).
// - Sub-module serial_sync_edge (synchronizers + rising-edge strobe + synced data), reusable for
//   other Arduino links.
// - Counters: bit_cnt CNT_W bits; gap_cnt $clog2(GAP_CYCLES+1) bits, saturating;
//   layer_idx $clog2(N_LAYERS) bits (min 1).
// TESTING
// - Reset: resetn=0 then 1 -> all outputs 0, busy=0; no layer_start while ser_clk idle for 10k cycles.
// - Full frame: 784 bits, MSB-first, ser_clk period 6 cycles; each layer_done 5 cycles after start;
//   class_in=7 -> pixels==sent vector, layer_start pulses 0,1,2 once each in order, result=7,
//   result_valid=1, frame_err=0.
// - Gap abort: 100 bits, then ser_clk idle for GAP_CYCLES+10 -> frame_err=1, busy=0, no layer_start.
//   A following good frame clears frame_err and produces a result.
// - Overrun: extra ser_clk edge during WAIT of layer 1 -> frame_err=1, pixels unchanged,
//   sequencing completes, result_valid=1.
// - Done filtering: assert layer_done[2] while waiting on layer 0, and layer_done[0] in the START
//   cycle -> neither advances the sequence; correct done advances it.
// - Reset mid-WAIT: resetn low during layer 1 -> outputs 0 immediately; next full frame with
//   class_in=3 -> result=3.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types and constants for the MNIST frame sequencer.
// Imported by the sequencer top and its helpers.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    START,
    WAIT,
    DONE
  } state_e;

  localparam int N_PIXELS_DEF = 784;
  localparam int CNT_W        = $clog2(N_PIXELS_DEF + 1);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_sync_edge.sv
// Two-flop synchronizers for an async two-wire serial link,
// plus a rising-edge strobe on the bit clock.
module serial_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic sdata_i,
  output logic strobe_o,
  output logic data_o
);

  logic [2:0] sclk_q;
  logic [1:0] sdat_q;

  // synchronizer chains; third clock flop remembers previous level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q <= '0;
      sdat_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      sdat_q <= {sdat_q[0], sdata_i};
    end
  end

  assign strobe_o = sclk_q[1] & ~sclk_q[2];
  assign data_o   = sdat_q[1];

endmodule

// File: rtl/nn_frame_sequencer.sv
// Receives a binary image over the serial link, then steps each
// layer engine through start/done and latches the argmax class.
module nn_frame_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int N_PIXELS   = N_PIXELS_DEF,
  parameter int N_LAYERS   = 3,
  parameter int CLASS_W    = 4,
  parameter int GAP_CYCLES = 4096
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                ser_clk,
  input  logic                ser_data,
  output logic [N_PIXELS-1:0] pixels,
  output logic [N_LAYERS-1:0] layer_start,
  input  logic [N_LAYERS-1:0] layer_done,
  input  logic [CLASS_W-1:0]  class_in,
  output logic [CLASS_W-1:0]  result,
  output logic                result_valid,
  output logic                busy,
  output logic                frame_err
);

  localparam int BIT_W  = $clog2(N_PIXELS + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int LIDX_W = idx_w(N_LAYERS);

  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(N_PIXELS);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic [LIDX_W-1:0] L_LAST   = LIDX_W'(N_LAYERS - 1);

  logic strobe;
  logic sbit;

  state_e              state_q, state_d;
  logic [N_PIXELS-1:0] pix_q, pix_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [LIDX_W-1:0]   lidx_q, lidx_d;
  logic [CLASS_W-1:0]  res_q, res_d;
  logic                rv_q, rv_d;
  logic                fe_q, fe_d;

  serial_sync_edge u_sync (
    .clk_i    (CLOCK_50),
    .rst_ni   (resetn),
    .sclk_i   (ser_clk),
    .sdata_i  (ser_data),
    .strobe_o (strobe),
    .data_o   (sbit)
  );

  // state and datapath registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      lidx_q    <= '0;
      res_q     <= '0;
      rv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      lidx_q    <= lidx_d;
      res_q     <= res_d;
      rv_q      <= rv_d;
      fe_q      <= fe_d;
    end
  end

  // next-state, counters and start pulse
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    lidx_d      = lidx_q;
    res_d       = res_q;
    rv_d        = rv_q;
    fe_d        = fe_q;
    layer_start = '0;
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          pix_d     = {pix_q[N_PIXELS-2:0], sbit};
          bit_cnt_d = BIT_W'(1);
          gap_cnt_d = '0;
          rv_d      = 1'b0;
          fe_d      = 1'b0;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (strobe) begin
          pix_d     = {pix_q[N_PIXELS-2:0], sbit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          gap_cnt_d = '0;
          if (bit_cnt_d == BIT_LAST)
            state_d = START;
        end else if (gap_cnt_q == GAP_MAX) begin
          fe_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      START: begin
        layer_start = N_LAYERS'(1) << lidx_q;
        state_d     = WAIT;
      end
      WAIT: begin
        if (layer_done[lidx_q]) begin
          if (lidx_q == L_LAST) begin
            state_d = DONE;
          end else begin
            lidx_d  = lidx_q + 1'b1;
            state_d = START;
          end
        end
      end
      DONE: begin
        res_d     = class_in;
        rv_d      = 1'b1;
        lidx_d    = '0;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a bit arriving while the network runs is dropped and flagged
    if (strobe && (state_q == START ||
                   state_q == WAIT  ||
                   state_q == DONE))
      fe_d = 1'b1;
  end

  assign pixels       = pix_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign frame_err    = fe_q;
  assign busy         = (state_q == RECV)  ||
                        (state_q == START) ||
                        (state_q == WAIT);

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Directed bench for the frame sequencer: full frames, gap abort,
// overrun, done filtering and reset during sequencing.
module tb_nn_frame_sequencer;

  logic         clk;
  logic         resetn;
  logic         ser_clk;
  logic         ser_data;
  logic [783:0] pixels;
  logic [2:0]   layer_start;
  logic [2:0]   layer_done;
  logic [3:0]   class_in;
  logic [3:0]   result;
  logic         result_valid;
  logic         busy;
  logic         frame_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int start_seq;
  logic [783:0] v;

  nn_frame_sequencer dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .ser_clk      (ser_clk),
    .ser_data     (ser_data),
    .pixels       (pixels),
    .layer_start  (layer_start),
    .layer_done   (layer_done),
    .class_in     (class_in),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record start pulses as a decimal digit string (layer k -> k+1)
  always @(negedge clk)
    if (|layer_start)
      for (int k = 0; k < 3; k++)
        if (layer_start[k]) start_seq = start_seq * 10 + k + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [783:0] obs,
                     input logic [783:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_data = b;
    ser_clk  = 1'b0;
    tick(3);
    ser_clk  = 1'b1;
    tick(3);
  endtask

  task automatic send_frame(input logic [783:0] f);
    for (int i = 783; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic rand_frame(output logic [783:0] f);
    for (int i = 0; i < 784; i++) f[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_start(input int k);
    int j;
    j = 0;
    while (!layer_start[k] && j < 200) begin
      tick(1);
      j++;
    end
    chk($sformatf("start%0d", k), 784'(layer_start[k]), 784'(1));
  endtask

  task automatic pulse_done(input int k);
    layer_done[k] = 1'b1;
    tick(1);
    layer_done = '0;
  endtask

  task automatic run_layers();
    for (int k = 0; k < 3; k++) begin
      wait_start(k);
      tick(5);
      pulse_done(k);
    end
    tick(3);
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_pix"}, pixels, '0);
    chk({p, "_ls"}, 784'(layer_start), '0);
    chk({p, "_res"}, 784'(result), '0);
    chk({p, "_rv"}, 784'(result_valid), '0);
    chk({p, "_busy"}, 784'(busy), '0);
    chk({p, "_fe"}, 784'(frame_err), '0);
  endtask

  initial begin
    resetn     = 1'b0;
    ser_clk    = 1'b0;
    ser_data   = 1'b0;
    layer_done = '0;
    class_in   = '0;
    start_seq  = 0;
    tick(3);
    chk_zero("rst");

    // idle link: nothing happens
    resetn = 1'b1;
    tick(10000);
    chk("idle_starts", 784'(start_seq), 784'(0));
    chk("idle_busy", 784'(busy), 784'(0));
    chk("idle_pix", pixels, '0);

    // full frame, class 7
    rand_frame(v);
    class_in  = 4'd7;
    start_seq = 0;
    send_frame(v);
    chk("f1_busy", 784'(busy), 784'(1));
    run_layers();
    chk("f1_pix", pixels, v);
    chk("f1_seq", 784'(start_seq), 784'(123));
    chk("f1_res", 784'(result), 784'(7));
    chk("f1_rv", 784'(result_valid), 784'(1));
    chk("f1_fe", 784'(frame_err), 784'(0));
    chk("f1_busy_end", 784'(busy), 784'(0));

    // gap abort after 100 bits
    rand_frame(v);
    start_seq = 0;
    for (int i = 783; i >= 684; i--) send_bit(v[i]);
    tick(4096 + 10);
    chk("gap_fe", 784'(frame_err), 784'(1));
    chk("gap_busy", 784'(busy), 784'(0));
    chk("gap_seq", 784'(start_seq), 784'(0));
    chk("gap_rv", 784'(result_valid), 784'(0));
    chk("gap_pix", 784'(pixels[99:0]), 784'(v[783:684]));

    // good frame after abort, class 5
    rand_frame(v);
    class_in  = 4'd5;
    start_seq = 0;
    send_frame(v);
    run_layers();
    chk("g2_fe", 784'(frame_err), 784'(0));
    chk("g2_res", 784'(result), 784'(5));
    chk("g2_rv", 784'(result_valid), 784'(1));
    chk("g2_pix", pixels, v);
    chk("g2_seq", 784'(start_seq), 784'(123));

    // overrun: extra bit during layer 1 wait, class 9
    rand_frame(v);
    class_in  = 4'd9;
    start_seq = 0;
    send_frame(v);
    wait_start(0);
    tick(5);
    pulse_done(0);
    wait_start(1);
    send_bit(1'b1);
    chk("ov_fe_early", 784'(frame_err), 784'(1));
    pulse_done(1);
    wait_start(2);
    tick(5);
    pulse_done(2);
    tick(3);
    chk("ov_fe", 784'(frame_err), 784'(1));
    chk("ov_pix", pixels, v);
    chk("ov_seq", 784'(start_seq), 784'(123));
    chk("ov_rv", 784'(result_valid), 784'(1));
    chk("ov_res", 784'(result), 784'(9));

    // done filtering, class 2
    rand_frame(v);
    class_in  = 4'd2;
    start_seq = 0;
    send_frame(v);
    wait_start(0);
    layer_done = 3'b001;
    tick(1);
    layer_done = 3'b100;
    tick(4);
    layer_done = '0;
    tick(1);
    chk("flt_seq", 784'(start_seq), 784'(1));
    chk("flt_busy", 784'(busy), 784'(1));
    chk("flt_ls", 784'(layer_start), 784'(0));
    pulse_done(0);
    wait_start(1);
    tick(5);
    pulse_done(1);
    wait_start(2);
    tick(5);
    pulse_done(2);
    tick(3);
    chk("flt_seq_end", 784'(start_seq), 784'(123));
    chk("flt_res", 784'(result), 784'(2));
    chk("flt_pix", pixels, v);

    // reset while waiting on layer 1
    rand_frame(v);
    class_in  = 4'd6;
    start_seq = 0;
    send_frame(v);
    wait_start(0);
    tick(5);
    pulse_done(0);
    wait_start(1);
    tick(2);
    resetn  = 1'b0;
    ser_clk = 1'b0;
    #1;
    chk_zero("mid");
    tick(3);
    resetn = 1'b1;
    tick(5);

    // recovery frame, class 3
    rand_frame(v);
    class_in  = 4'd3;
    start_seq = 0;
    send_frame(v);
    run_layers();
    chk("rec_res", 784'(result), 784'(3));
    chk("rec_rv", 784'(result_valid), 784'(1));
    chk("rec_pix", pixels, v);
    chk("rec_seq", 784'(start_seq), 784'(123));
    chk("rec_fe", 784'(frame_err), 784'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
